// File: rtl/lsu_mem_responder_if.sv
// Data-memory port of the LSU responder: req/gnt/rvalid handshake plus write payload.
// The master side (responder) drives the request; the slave side (RAM / bridge) answers.
interface lsu_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();
  logic                mem_req_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W/8-1:0] mem_wstrb_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [DATA_W-1:0]   mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_mem_responder.sv
// Memory-side end of the FU-register-to-RAM path: one load and/or one store per request.
// Optional watchdog abort per memory phase is enabled by defining RESP_TIMEOUT_EN.
module lsu_mem_responder #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid_i,
  input  logic [ADDR_W-1:0]      readAddr_i,
  input  logic [ADDR_W-1:0]      writeAddr_i,
  input  logic [DATA_W-1:0]      writeData_i,
  input  logic [DATA_W/16-1:0]   writeMask_i,
  output logic                   ready_o,
  output logic                   dataOk_o,
  output logic [DATA_W-1:0]      readData_o,
  output logic [2:0]             writeState_o,
  output logic                   error_o,
  lsu_mem_responder_if.master    mem
);

  localparam int MASK_W = DATA_W / 16;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_ARM, WR_REQ} state_t;

  state_t              state, state_nxt;
  logic                accept, rd_done, rd_abort, wr_done, wr_abort, timeout;
  logic [ADDR_W-1:0]   rd_addr, wr_addr;
  logic [DATA_W-1:0]   wr_data, rdata_q;
  logic [STRB_W-1:0]   wr_strb;
  logic                st_pend, data_ok_q, wr_done_q, is_wr;

  // Each mask bit covers one 16-bit lane of the data word.
  function automatic logic [STRB_W-1:0] expand_mask(input logic [MASK_W-1:0] m);
    logic [STRB_W-1:0] s;
    s = '0;
    for (int k = 0; k < MASK_W; k++) s[2*k +: 2] = {2{m[k]}};
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_done   = 1'b0;
    rd_abort  = 1'b0;
    wr_done   = 1'b0;
    wr_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i && (|readAddr_i || |writeAddr_i)) begin
          accept    = 1'b1;
          state_nxt = (|readAddr_i) ? RD_REQ : WR_REQ;
        end
      end
      RD_REQ: begin
        if (mem.mem_gnt_i && mem.mem_rvalid_i) begin
          rd_done   = 1'b1;
          state_nxt = st_pend ? WR_ARM : IDLE;
        end else if (mem.mem_gnt_i) begin
          state_nxt = RD_WAIT;
        end else if (timeout) begin
          rd_abort  = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (mem.mem_rvalid_i) begin
          rd_done   = 1'b1;
          state_nxt = st_pend ? WR_ARM : IDLE;
        end else if (timeout) begin
          rd_abort  = 1'b1;
          state_nxt = IDLE;
        end
      end
      // One idle cycle so the store request follows the dataOk pulse, not overlaps it.
      WR_ARM: state_nxt = WR_REQ;
      WR_REQ: begin
        if (mem.mem_gnt_i) begin
          wr_done   = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          wr_abort  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_strb   <= '0;
      st_pend   <= 1'b0;
      rdata_q   <= '0;
      data_ok_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      data_ok_q <= rd_done | rd_abort;
      wr_done_q <= wr_done | wr_abort;
      if (rd_done)       rdata_q <= mem.mem_rdata_i;
      else if (rd_abort) rdata_q <= '0;
      if (accept) begin
        rd_addr <= readAddr_i;
        wr_addr <= writeAddr_i;
        wr_data <= writeData_i;
        wr_strb <= expand_mask(writeMask_i);
        st_pend <= (|readAddr_i) && (|writeAddr_i);
      end
    end
  end

`ifdef RESP_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // Counts cycles spent in the current memory phase; any state change restarts it.
  always_ff @(posedge clk) begin
    if (!reset_n || state_nxt != state)         tmo_cnt <= '0;
    else if (state != IDLE && state != WR_ARM)  tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= rd_abort | wr_abort;
  end

  assign timeout = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign error_o = err_q;
`else
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

  assign is_wr            = (state == WR_REQ);
  assign ready_o          = (state == IDLE);
  assign dataOk_o         = data_ok_q;
  assign readData_o       = rdata_q;
  assign writeState_o     = wr_done_q ? 3'b111 : (is_wr ? 3'b001 : 3'b000);
  assign mem.mem_req_o    = (state == RD_REQ) || is_wr;
  assign mem.mem_we_o     = is_wr;
  assign mem.mem_addr_o   = is_wr ? wr_addr : rd_addr;
  assign mem.mem_wdata_o  = wr_data;
  assign mem.mem_wstrb_o  = is_wr ? wr_strb : '0;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder with load/store scoreboards checked on completion.
// Watchdog scenarios run when RESP_TIMEOUT_EN is defined; otherwise the no-abort path is checked.
module tb_lsu_mem_responder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] readAddr_i = '0;
  logic [31:0] writeAddr_i = '0;
  logic [63:0] writeData_i = '0;
  logic [3:0]  writeMask_i = '0;
  logic        ready_o, dataOk_o, error_o;
  logic [63:0] readData_o;
  logic [2:0]  writeState_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } wr_exp_t;

  logic [63:0] exp_rd[$];
  wr_exp_t     exp_wr[$];

  lsu_mem_responder_if #(.ADDR_W(32), .DATA_W(64)) mem_if ();

  lsu_mem_responder #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_i      (valid_i),
    .readAddr_i   (readAddr_i),
    .writeAddr_i  (writeAddr_i),
    .writeData_i  (writeData_i),
    .writeMask_i  (writeMask_i),
    .ready_o      (ready_o),
    .dataOk_o     (dataOk_o),
    .readData_o   (readData_o),
    .writeState_o (writeState_o),
    .error_o      (error_o),
    .mem          (mem_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: loads pop on dataOk, stores pop when the grant lands.
  always @(negedge clk) begin
    if (reset_n) begin
      if (dataOk_o) begin
        chk("load_expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) chk("load_data", readData_o, exp_rd.pop_front());
      end
      if (mem_if.mem_req_o && mem_if.mem_we_o && mem_if.mem_gnt_i) begin
        chk("store_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          wr_exp_t w;
          w = exp_wr.pop_front();
          chk("store_addr", 64'(mem_if.mem_addr_o), 64'(w.addr));
          chk("store_data", mem_if.mem_wdata_o, w.data);
          chk("store_strb", 64'(mem_if.mem_wstrb_o), 64'(w.strb));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_if.mem_gnt_i    = 1'b0;
    mem_if.mem_rvalid_i = 1'b0;
    mem_if.mem_rdata_i  = '0;

    // Reset values
    step(); step();
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_dataok", 64'(dataOk_o), 64'd0);
    chk("rst_rdata", readData_o, 64'd0);
    chk("rst_wstate", 64'(writeState_o), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    chk("rst_req", 64'(mem_if.mem_req_o), 64'd0);
    chk("rst_we", 64'(mem_if.mem_we_o), 64'd0);
    chk("rst_addr", 64'(mem_if.mem_addr_o), 64'd0);
    chk("rst_wdata", mem_if.mem_wdata_o, 64'd0);
    chk("rst_wstrb", 64'(mem_if.mem_wstrb_o), 64'd0);
    reset_n = 1'b1;
    step();

    // Reset held two cycles in RD_WAIT; the late rvalid must be ignored
    valid_i = 1'b1; readAddr_i = 32'h8000_0100;
    step();
    valid_i = 1'b0; readAddr_i = '0;
    chk("mid_req", 64'(mem_if.mem_req_o), 64'd1);
    chk("mid_ready", 64'(ready_o), 64'd0);
    mem_if.mem_gnt_i = 1'b1;
    step();
    mem_if.mem_gnt_i = 1'b0;
    chk("mid_wait_req", 64'(mem_if.mem_req_o), 64'd0);
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    chk("mid_rst_req", 64'(mem_if.mem_req_o), 64'd0);
    chk("mid_rst_addr", 64'(mem_if.mem_addr_o), 64'd0);
    mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
    step();
    mem_if.mem_rvalid_i = 1'b0;
    step();
    chk("mid_late_dataok", 64'(dataOk_o), 64'd0);
    chk("mid_late_rdata", readData_o, 64'd0);

    // Valid with both addresses zero is not a request
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("null_ready", 64'(ready_o), 64'd1);
    chk("null_req", 64'(mem_if.mem_req_o), 64'd0);

    // Plain load: gnt two cycles in, rvalid two cycles later
    valid_i = 1'b1; readAddr_i = 32'h8000_0010;
    exp_rd.push_back(64'hDEAD_BEEF_CAFE_F00D);
    step();
    valid_i = 1'b0; readAddr_i = '0;
    chk("ld_req", 64'(mem_if.mem_req_o), 64'd1);
    chk("ld_we", 64'(mem_if.mem_we_o), 64'd0);
    chk("ld_addr", 64'(mem_if.mem_addr_o), 64'h8000_0010);
    step();
    chk("ld_stall_req", 64'(mem_if.mem_req_o), 64'd1);
    chk("ld_stall_addr", 64'(mem_if.mem_addr_o), 64'h8000_0010);
    mem_if.mem_gnt_i = 1'b1;
    step();
    mem_if.mem_gnt_i = 1'b0;
    chk("ld_wait_req", 64'(mem_if.mem_req_o), 64'd0);
    step();
    chk("ld_wait_dataok", 64'(dataOk_o), 64'd0);
    mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    mem_if.mem_rvalid_i = 1'b0; mem_if.mem_rdata_i = 64'h5555_5555_5555_5555;
    chk("ld_dataok", 64'(dataOk_o), 64'd1);
    chk("ld_rdata", readData_o, 64'hDEAD_BEEF_CAFE_F00D);
    chk("ld_ready", 64'(ready_o), 64'd1);
    step();
    chk("ld_pulse_end", 64'(dataOk_o), 64'd0);
    chk("ld_rdata_hold", readData_o, 64'hDEAD_BEEF_CAFE_F00D);

    // Store-only, one stall cycle; a busy-time valid must be ignored
    valid_i = 1'b1; writeAddr_i = 32'h8000_0020;
    writeData_i = 64'h1122_3344_5566_7788; writeMask_i = 4'b0101;
    exp_wr.push_back('{addr: 32'h8000_0020, data: 64'h1122_3344_5566_7788, strb: 8'h33});
    step();
    writeAddr_i = '0; writeData_i = '1; writeMask_i = 4'b1111; readAddr_i = 32'h9000_0000;
    chk("st_req", 64'(mem_if.mem_req_o), 64'd1);
    chk("st_we", 64'(mem_if.mem_we_o), 64'd1);
    chk("st_wstrb", 64'(mem_if.mem_wstrb_o), 64'h33);
    chk("st_wstate", 64'(writeState_o), 64'd1);
    step();
    valid_i = 1'b0; readAddr_i = '0;
    chk("st_stall_addr", 64'(mem_if.mem_addr_o), 64'h8000_0020);
    chk("st_stall_wdata", mem_if.mem_wdata_o, 64'h1122_3344_5566_7788);
    chk("st_stall_wstate", 64'(writeState_o), 64'd1);
    mem_if.mem_gnt_i = 1'b1;
    step();
    mem_if.mem_gnt_i = 1'b0;
    chk("st_done", 64'(writeState_o), 64'h7);
    chk("st_done_ready", 64'(ready_o), 64'd1);
    chk("st_done_req", 64'(mem_if.mem_req_o), 64'd0);
    step();
    chk("st_idle", 64'(writeState_o), 64'd0);

    // Load + store together, rvalid with gnt in the same cycle
    valid_i = 1'b1; readAddr_i = 32'h8000_0040; writeAddr_i = 32'h8000_0048;
    writeData_i = 64'hA5A5_0000_FFFF_1234; writeMask_i = 4'b1010;
    exp_rd.push_back(64'h0123_4567_89AB_CDEF);
    exp_wr.push_back('{addr: 32'h8000_0048, data: 64'hA5A5_0000_FFFF_1234, strb: 8'hCC});
    step();
    valid_i = 1'b0; readAddr_i = '0; writeAddr_i = '0;
    chk("ls_we_first", 64'(mem_if.mem_we_o), 64'd0);
    chk("ls_rd_addr", 64'(mem_if.mem_addr_o), 64'h8000_0040);
    mem_if.mem_gnt_i = 1'b1; mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 64'h0123_4567_89AB_CDEF;
    step();
    mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0;
    chk("ls_dataok", 64'(dataOk_o), 64'd1);
    chk("ls_ready_low", 64'(ready_o), 64'd0);
    chk("ls_no_req_yet", 64'(mem_if.mem_req_o), 64'd0);
    step();
    chk("ls_st_req", 64'(mem_if.mem_req_o), 64'd1);
    chk("ls_st_we", 64'(mem_if.mem_we_o), 64'd1);
    chk("ls_st_addr", 64'(mem_if.mem_addr_o), 64'h8000_0048);
    chk("ls_st_wstate", 64'(writeState_o), 64'd1);
    chk("ls_ready_low2", 64'(ready_o), 64'd0);
    mem_if.mem_gnt_i = 1'b1;
    step();
    mem_if.mem_gnt_i = 1'b0;
    chk("ls_st_done", 64'(writeState_o), 64'h7);
    chk("ls_ready_back", 64'(ready_o), 64'd1);

    // Back-to-back: new load on the ready rising cycle
    valid_i = 1'b1; readAddr_i = 32'h8000_0080;
    exp_rd.push_back(64'hFEED_FACE_0000_0001);
    step();
    valid_i = 1'b0; readAddr_i = '0;
    chk("b2b_req", 64'(mem_if.mem_req_o), 64'd1);
    chk("b2b_addr", 64'(mem_if.mem_addr_o), 64'h8000_0080);
    mem_if.mem_gnt_i = 1'b1;
    step();
    mem_if.mem_gnt_i = 1'b0;
    mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 64'hFEED_FACE_0000_0001;
    step();
    mem_if.mem_rvalid_i = 1'b0;
    chk("b2b_dataok", 64'(dataOk_o), 64'd1);
    valid_i = 1'b1; readAddr_i = 32'h8000_00C0;
    exp_rd.push_back(64'h7777_8888_9999_AAAA);
    step();
    valid_i = 1'b0; readAddr_i = '0;
    chk("b2b2_req", 64'(mem_if.mem_req_o), 64'd1);
    chk("b2b2_addr", 64'(mem_if.mem_addr_o), 64'h8000_00C0);
    mem_if.mem_gnt_i = 1'b1; mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 64'h7777_8888_9999_AAAA;
    step();
    mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0;
    chk("b2b2_rdata", readData_o, 64'h7777_8888_9999_AAAA);

`ifdef RESP_TIMEOUT_EN
    // Load with no grant: abort after 16 cycles in RD_REQ
    valid_i = 1'b1; readAddr_i = 32'h8000_00F0;
    step();
    valid_i = 1'b0; readAddr_i = '0;
    for (int i = 0; i < 15; i++) step();
    chk("to_ld_pre_err", 64'(error_o), 64'd0);
    chk("to_ld_pre_req", 64'(mem_if.mem_req_o), 64'd1);
    exp_rd.push_back(64'd0);
    step();
    chk("to_ld_err", 64'(error_o), 64'd1);
    chk("to_ld_dataok", 64'(dataOk_o), 64'd1);
    chk("to_ld_rdata", readData_o, 64'd0);
    chk("to_ld_ready", 64'(ready_o), 64'd1);
    chk("to_ld_req", 64'(mem_if.mem_req_o), 64'd0);
    step();
    chk("to_ld_err_end", 64'(error_o), 64'd0);

    // Store with no grant: abort reports 111 and error
    valid_i = 1'b1; writeAddr_i = 32'h8000_0100; writeMask_i = 4'b0001;
    step();
    valid_i = 1'b0; writeAddr_i = '0;
    for (int i = 0; i < 15; i++) step();
    chk("to_st_pre_wstate", 64'(writeState_o), 64'd1);
    step();
    chk("to_st_err", 64'(error_o), 64'd1);
    chk("to_st_wstate", 64'(writeState_o), 64'h7);
    chk("to_st_ready", 64'(ready_o), 64'd1);
`else
    // Without the watchdog a stalled load waits indefinitely
    valid_i = 1'b1; readAddr_i = 32'h8000_00F0;
    exp_rd.push_back(64'h0F0F_0F0F_0F0F_0F0F);
    step();
    valid_i = 1'b0; readAddr_i = '0;
    for (int i = 0; i < 300; i++) step();
    chk("nt_err", 64'(error_o), 64'd0);
    chk("nt_req", 64'(mem_if.mem_req_o), 64'd1);
    chk("nt_ready", 64'(ready_o), 64'd0);
    chk("nt_dataok", 64'(dataOk_o), 64'd0);
    mem_if.mem_gnt_i = 1'b1; mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 64'h0F0F_0F0F_0F0F_0F0F;
    step();
    mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0;
    chk("nt_dataok_late", 64'(dataOk_o), 64'd1);
    chk("nt_err_late", 64'(error_o), 64'd0);
`endif

    step(); step();
    chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
